// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the integer register file and its writeback port.
//
// Contents:
//   - pipe_stage_e   : pipeline stage identifiers used across the core.
//   - REG_N, REG_NREG, REG_AW : default data width, register count, index width.
//   - REG_ZERO       : index of the hardwired-zero register x0.
//   - reg_idx_t      : register index type at the default index width.
package regfile_wb_pkg;

    typedef enum logic [2:0] {
        StageIf,
        StageId,
        StageEx,
        StageMem,
        StageWb
    } pipe_stage_e;

    // The writeback port is fed from the EX/MEM stage register.
    localparam pipe_stage_e WB_SOURCE_STAGE = StageMem;

    localparam int unsigned REG_N    = 32;
    localparam int unsigned REG_NREG = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard and issue stall generation.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset.
//   wb_write, wb_register : writeback in this cycle; clears the matching busy bit.
//   rs1_addr, rs2_addr    : source indices of the instruction at issue.
//   issue_valid/write/rd  : instruction at issue and its destination.
//   flush                 : discard the instruction at issue this cycle.
//   stall                 : hold the instruction at issue (combinational).
//   busy_vec              : registered busy bits, one per register.
module regfile_scoreboard
    import regfile_wb_pkg::*;
#(
    parameter int unsigned NREG = REG_NREG,
    parameter int unsigned AW   = REG_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_write,
    input  logic [AW-1:0]   wb_register,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            issue_valid,
    input  logic            issue_write,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] hz_vec;
    logic            accept;

    // A register being written back this cycle is no longer a hazard: the
    // read ports bypass the value and the WAW ordering is already resolved.
    always_comb begin
        clr_vec = '0;
        hz_vec  = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            clr_vec[i] = wb_write && (wb_register == AW'(i));
            hz_vec[i]  = busy_q[i] && !clr_vec[i];
        end
    end

    // Index widths cover NREG exactly, so direct vector indexing is in range.
    assign stall = issue_valid && !flush &&
                   (hz_vec[rs1_addr] || hz_vec[rs2_addr] ||
                    (issue_write && hz_vec[issue_rd]));

    assign accept = issue_valid && !flush && !stall && issue_write &&
                    (issue_rd != AW'(REG_ZERO));

    // Set is applied after clear so a new writer wins over a retiring one.
    always_comb begin
        busy_d = busy_q & ~clr_vec;
        if (accept) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb.sv
// Integer register file with one writeback port, two combinational read ports
// with same-cycle write bypass, x0 hardwired to zero and a busy scoreboard.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset.
//   wb_write              : writeback enable from the EX/MEM stage register.
//   wb_register, wb_data  : writeback destination index and data.
//   rs1_addr, rs2_addr    : read port indices.
//   rs1_data, rs2_data    : read port data (combinational).
//   issue_valid/write/rd  : instruction presented by decode and its destination.
//   flush                 : discard the presented instruction this cycle.
//   stall                 : presented instruction must be held (combinational).
//   busy_vec              : registered scoreboard bits.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int unsigned N    = REG_N,
    parameter int unsigned NREG = REG_NREG,
    parameter int unsigned AW   = REG_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_write,
    input  logic [AW-1:0]   wb_register,
    input  logic [N-1:0]    wb_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [N-1:0]    rs1_data,
    output logic [N-1:0]    rs2_data,
    input  logic            issue_valid,
    input  logic            issue_write,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_vec
);

    logic [N-1:0] regs_q [NREG];
    logic         wb_en;

    assign wb_en = wb_write && (wb_register != AW'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_register] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == AW'(REG_ZERO)) begin
            rs1_data = '0;
        end else if (wb_write && (wb_register == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == AW'(REG_ZERO)) begin
            rs2_data = '0;
        end else if (wb_write && (wb_register == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wb_write    (wb_write),
        .wb_register (wb_register),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .issue_valid (issue_valid),
        .issue_write (issue_write),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    localparam int N    = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            wb_write;
    logic [AW-1:0]   wb_register;
    logic [N-1:0]    wb_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [N-1:0]    rs1_data;
    logic [N-1:0]    rs2_data;
    logic            issue_valid;
    logic            issue_write;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic            stall;
    logic [NREG-1:0] busy_vec;

    regfile_wb #(
        .N    (N),
        .NREG (NREG),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_write    (wb_write),
        .wb_register (wb_register),
        .wb_data     (wb_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_write (issue_write),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural contents plus a set of in-flight writers.
    logic [N-1:0] model_reg [NREG];
    bit           model_busy [NREG];
    bit           model_valid = 0;
    bit           model_acc;

    function automatic logic [N-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_write && wb_register == a) return wb_data;
        return model_reg[a];
    endfunction

    function automatic bit in_flight(input logic [AW-1:0] r);
        return (r != 0) && model_busy[r] && !(wb_write && wb_register == r);
    endfunction

    function automatic bit exp_stall();
        return issue_valid && !flush &&
               (in_flight(rs1_addr) || in_flight(rs2_addr) ||
                (issue_write && in_flight(issue_rd)));
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = model_busy[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                model_reg[i]  = '0;
                model_busy[i] = 0;
            end
            model_valid = 1;
        end else if (model_valid) begin
            model_acc = issue_valid && !flush && !exp_stall() && issue_write && issue_rd != 0;
            if (wb_write && wb_register != 0) begin
                model_reg[wb_register]  = wb_data;
                model_busy[wb_register] = 0;
            end
            if (model_acc) model_busy[issue_rd] = 1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("rs1_data", rs1_data, exp_read(rs1_addr));
            check("rs2_data", rs2_data, exp_read(rs2_addr));
            check("stall", {31'b0, stall}, {31'b0, exp_stall()});
            check("busy_vec", busy_vec, exp_busy());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_write    = 0;
        issue_valid = 0;
        issue_write = 0;
        flush       = 0;
    endtask

    logic [AW-1:0] tbl_idx  [4];
    logic [N-1:0]  tbl_data [4];

    initial begin
        tbl_idx[0] = 5'd1;  tbl_data[0] = 32'h0000_0001;
        tbl_idx[1] = 5'd2;  tbl_data[1] = 32'hFFFF_FFFF;
        tbl_idx[2] = 5'd15; tbl_data[2] = 32'h8000_0000;
        tbl_idx[3] = 5'd31; tbl_data[3] = 32'h1357_9BDF;

        reset = 1; wb_write = 0; wb_register = 0; wb_data = 0;
        rs1_addr = 0; rs2_addr = 0; issue_valid = 0; issue_write = 0;
        issue_rd = 0; flush = 0;
        tick();

        // Reset then read
        reset = 0; rs1_addr = 5; rs2_addr = 31; issue_valid = 1;
        #1;
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);
        check("reset_busy", busy_vec, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        tick(); idle();

        // Write with same-cycle bypass, then from storage
        wb_write = 1; wb_register = 7; wb_data = 32'hDEADBEEF; rs1_addr = 7;
        #1 check("bypass_rs1", rs1_data, 32'hDEADBEEF);
        tick(); wb_write = 0;
        #1 check("stored_rs1", rs1_data, 32'hDEADBEEF);
        tick();

        // x0 protection
        wb_write = 1; wb_register = 0; wb_data = 32'h12345678; rs1_addr = 0;
        #1 check("x0_bypass", rs1_data, 32'h0);
        tick(); wb_write = 0;
        #1 check("x0_read", rs1_data, 32'h0);
        check("x0_busy", {31'b0, busy_vec[0]}, 32'h0);
        tick();

        // RAW: accept rd=3, then read rs1=3 until writeback
        issue_valid = 1; issue_write = 1; issue_rd = 3; rs1_addr = 0; rs2_addr = 0;
        #1 check("raw_accept_stall", {31'b0, stall}, 32'h0);
        tick();
        issue_write = 0; rs1_addr = 3;
        #1 check("raw_stall1", {31'b0, stall}, 32'h1);
        check("raw_busy3", {31'b0, busy_vec[3]}, 32'h1);
        tick();
        #1 check("raw_stall2", {31'b0, stall}, 32'h1);
        wb_write = 1; wb_register = 3; wb_data = 32'hA5A5_0003;
        #1 check("raw_release", {31'b0, stall}, 32'h0);
        check("raw_bypass", rs1_data, 32'hA5A5_0003);
        tick(); idle();
        #1 check("raw_busy3_clr", {31'b0, busy_vec[3]}, 32'h0);
        check("raw_stored", rs1_data, 32'hA5A5_0003);
        tick();

        // Set/clear collision on index 4
        issue_valid = 1; issue_write = 1; issue_rd = 4; rs1_addr = 0;
        tick();
        wb_write = 1; wb_register = 4; wb_data = 32'h0000_0044;
        #1 check("coll_stall", {31'b0, stall}, 32'h0);
        tick(); idle();
        #1 check("coll_busy4", {31'b0, busy_vec[4]}, 32'h1);
        wb_write = 1; wb_register = 4; wb_data = 32'h0000_0045;
        tick(); idle();
        #1 check("coll_busy4_clr", {31'b0, busy_vec[4]}, 32'h0);

        // WAW on index 9
        issue_valid = 1; issue_write = 1; issue_rd = 9;
        tick();
        #1 check("waw_stall", {31'b0, stall}, 32'h1);
        tick(); idle();
        #1 check("waw_busy", busy_vec, 32'h0000_0200);

        // Flush suppresses acceptance but leaves busy bits alone
        issue_valid = 1; issue_write = 1; issue_rd = 10; flush = 1;
        #1 check("flush_stall", {31'b0, stall}, 32'h0);
        tick();
        issue_rd = 9;
        #1 check("flush_busy_stall", {31'b0, stall}, 32'h0);
        tick(); idle();
        #1 check("flush_busy", busy_vec, 32'h0000_0200);

        // Table of writes, then read them back pairwise
        for (int i = 0; i < 4; i++) begin
            wb_write = 1; wb_register = tbl_idx[i]; wb_data = tbl_data[i];
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rs1_addr = tbl_idx[i]; rs2_addr = tbl_idx[3 - i];
            #1 check("tbl_rs1", rs1_data, tbl_data[i]);
            check("tbl_rs2", rs2_data, tbl_data[3 - i]);
            tick();
        end

        // Mid-operation reset beats same-cycle write and acceptance
        reset = 1; wb_write = 1; wb_register = 12; wb_data = 32'hCAFE_F00D;
        issue_valid = 1; issue_write = 1; issue_rd = 11;
        tick();
        reset = 0; idle(); rs1_addr = 12; rs2_addr = 7;
        #1 check("mreset_busy", busy_vec, 32'h0);
        check("mreset_rs1", rs1_data, 32'h0);
        check("mreset_rs2", rs2_data, 32'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Integer register file with a writeback port, two combinational read ports and a per-register busy scoreboard.
- The writeback port consumes the write-enable, destination-index and data signals leaving the EX/MEM stage register.
- The read ports and stall output serve the decode/issue stage.
- Provides write-to-read bypass, x0 hardwired to zero, and a stall request for RAW and WAW hazards against in-flight writes.

Parameters:
- N, 32, data width of each register.
- NREG, 32, number of architectural registers. Must be a power of two; x0 is index 0.
- AW, 5, register index width, equal to log2(NREG).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- wb_write  input  1  writeback enable, from the EX/MEM write output.
- wb_register  input  AW  writeback destination index.
- wb_data  input  N  writeback data.
- rs1_addr  input  AW  read port 1 index.
- rs2_addr  input  AW  read port 2 index.
- rs1_data  output  N  read port 1 data, combinational.
- rs2_data  output  N  read port 2 data, combinational.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_write  input  1  the presented instruction writes a destination.
- issue_rd  input  AW  destination of the presented instruction.
- flush  input  1  active-high; the presented instruction is discarded and not accepted.
- stall  output  1  the presented instruction must be held; combinational.
- busy_vec  output  NREG  registered scoreboard bits, for debug and verification.

Behaviour:
- Reset:
  - At a rising edge with reset=1, all NREG registers clear to 0 and busy_vec clears to 0.
  - The writeback and issue inputs are ignored in that cycle.
  - rs1_data and rs2_data read 0 for every index while storage is cleared.
- Write:
  - At a rising edge with reset=0, wb_write=1 and wb_register!=0, reg[wb_register] takes wb_data.
  - Writes to index 0 are dropped.
- Read (combinational, per port):
  - addr==0 returns 0.
  - If wb_write=1, wb_register==addr and addr!=0, the port returns wb_data (same-cycle bypass).
  - Otherwise the port returns reg[addr].
- Hazard terms:
  - clr(i) = wb_write && wb_register==i && i!=0.
  - hz(i) = busy[i] && !clr(i) && i!=0.
- stall = issue_valid && !flush && (hz(rs1_addr) || hz(rs2_addr) || (issue_write && hz(issue_rd))).
  - The issue_rd term covers the WAW case. It guarantees at most one in-flight writer per register, so one busy bit per register is enough.
- accept = issue_valid && !flush && !stall && issue_write && issue_rd!=0.
- Scoreboard update at each rising edge with reset=0:
  - busy[i] clears when clr(i).
  - busy[i] sets when accept && issue_rd==i.
  - When set and clear hit the same index in the same cycle, set wins and the bit stays 1. The new writer is now in flight.
- busy[0] is always 0.
- flush only suppresses acceptance in its own cycle. It does not clear busy bits, because writes already in flight still complete through writeback.
- A writeback to a register whose busy bit is 0 still updates storage and leaves the bit at 0.
- Reset asserted mid-operation overrides any same-cycle write and any same-cycle scoreboard update.
- Latency:
  - A written value is visible on the read ports in the write cycle through the bypass, and from storage in the next cycle.
  - A busy bit affects stall one cycle after acceptance.

Decomposition:
- Shared package (alongside the pipeline-stage constants) holds:
  - REG_ZERO = 0.
  - The AW and N defaults.
  - A reg_idx_t typedef of width AW.
- One sub-module, regfile_scoreboard, is natural. It holds busy_vec, the set/clear/priority logic and the stall equation.
- regfile_wb instantiates regfile_scoreboard next to the storage array and the bypass muxes.

Test Plan:
- Reset then read: assert reset for 1 cycle, then read rs1=5 and rs2=31 -> both return 0, busy_vec=0, stall=0.
- Write and bypass:
  - Stimulus: wb_write=1, wb_register=7, wb_data=0xDEADBEEF, rs1_addr=7 in the same cycle.
  - Response: rs1_data=0xDEADBEEF that cycle; next cycle with wb_write=0, rs1_data is still 0xDEADBEEF.
- x0 protection: write 0x12345678 to index 0, then read rs1=0 -> rs1_data=0 and busy_vec[0]=0.
- RAW stall:
  - Stimulus: accept an issue with rd=3; next cycle issue with rs1=3.
  - Response: stall=1 until the cycle where wb_write=1 and wb_register=3. In that cycle stall=0 and rs1_data equals wb_data; busy[3]=0 afterwards.
- Set/clear collision: while busy[4]=1, apply wb_write to index 4 and accept an issue with rd=4 in the same cycle -> busy[4] stays 1 next cycle.
- WAW and flush:
  - While busy[9]=1, issue with rd=9 -> stall=1 and busy unchanged.
  - Issue with rd=10 and flush=1 -> stall=0 and busy[10] stays 0.
